// File: rtl/inst_mem_loader_if.sv
// rtl/inst_mem_loader_if.sv - instruction RAM write/readback port between loader and RAM
interface inst_mem_loader_if #(
  parameter int ADDR_W = 6
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - packs switch bytes into 32-bit words and writes them to instruction RAM
// Optional readback check enabled by defining INST_LOADER_VERIFY_EN.
module inst_mem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORDS  = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [7:0]          byte_in,
  input  logic                byte_strobe,
  inst_mem_loader_if.master   mem,
  output logic [1:0]          byte_idx,
  output logic                done,
  output logic                dropped,
  output logic                error
);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_WRITE,
    S_VERIFY_WAIT,
    S_VERIFY_CMP,
    S_FULL
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        byte_idx_q;
  logic              we_q;
  logic              done_q;
  logic              dropped_q;
  logic              error_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_COLLECT;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_idx_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      error_q    <= 1'b0;
    end else if (clear) begin
      // Any strobe in the same cycle is swallowed by the restart.
      state      <= S_COLLECT;
      addr_q     <= '0;
      byte_idx_q <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      dropped_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      if (byte_strobe && (state != S_COLLECT)) begin
        dropped_q <= 1'b1;
      end

      case (state)
        S_COLLECT: begin
          if (byte_strobe) begin
            wdata_q[8*byte_idx_q +: 8] <= byte_in;
            byte_idx_q                 <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              we_q  <= 1'b1;
              state <= S_WRITE;
            end
          end
        end

        S_WRITE: begin
          we_q <= 1'b0;
`ifdef INST_LOADER_VERIFY_EN
          state <= S_VERIFY_WAIT;
`else
          if (addr_q == LAST_ADDR) begin
            done_q <= 1'b1;
            state  <= S_FULL;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            state  <= S_COLLECT;
          end
`endif
        end

`ifdef INST_LOADER_VERIFY_EN
        // Address is held here so the RAM's registered read returns the word just written.
        S_VERIFY_WAIT: begin
          state <= S_VERIFY_CMP;
        end

        S_VERIFY_CMP: begin
          if (mem.mem_rdata != wdata_q) begin
            error_q <= 1'b1;
          end
          if (addr_q == LAST_ADDR) begin
            done_q <= 1'b1;
            state  <= S_FULL;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            state  <= S_COLLECT;
          end
        end
`endif

        S_FULL: begin
          done_q <= 1'b1;
        end

        default: begin
          state <= S_COLLECT;
        end
      endcase
    end
  end

`ifndef INST_LOADER_VERIFY_EN
  wire unused_rdata = ^mem.mem_rdata;
`endif

  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign byte_idx      = byte_idx_q;
  assign done          = done_q;
  assign dropped       = dropped_q;
  assign error         = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// tb/tb_inst_mem_loader.sv - directed self-checking bench for inst_mem_loader
module tb_inst_mem_loader;

  localparam int ADDR_W = 6;
  localparam int WORDS  = 64;
`ifdef INST_LOADER_VERIFY_EN
  localparam int SETTLE = 4;
  localparam int SP     = 2;
`else
  localparam int SETTLE = 2;
  localparam int SP     = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       byte_strobe = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic [1:0] byte_idx;
  logic       done;
  logic       dropped;
  logic       error;

  int n_checks = 0;
  int n_fail   = 0;
  int we_count = 0;
  int w0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_data = '0;
  logic [31:0]       ram [0:WORDS-1];
  logic              corrupt_en = 1'b0;

  inst_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_mem_loader #(.ADDR_W(ADDR_W), .WORDS(WORDS)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .byte_in     (byte_in),
    .byte_strobe (byte_strobe),
    .mem         (bus),
    .byte_idx    (byte_idx),
    .done        (done),
    .dropped     (dropped),
    .error       (error)
  );

  always #10 clock = ~clock;

  // RAM with one-cycle registered read; optionally flips bit 5 of word 2 on write.
  always @(posedge clock) begin
    if (bus.mem_we === 1'b1)
      ram[bus.mem_addr] <= (corrupt_en && bus.mem_addr == 6'd2) ? (bus.mem_wdata ^ 32'h20) : bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      we_count  = we_count + 1;
      last_addr = bus.mem_addr;
      last_data = bus.mem_wdata;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    byte_in = b; byte_strobe = 1'b1;
    @(posedge clock); #1;
    byte_strobe = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    idle(SETTLE);
  endtask

  task automatic pulse_clear(input logic with_strobe, input logic [7:0] b);
    @(posedge clock); #1;
    clear = 1'b1; byte_strobe = with_strobe; byte_in = b;
    @(posedge clock); #1;
    clear = 1'b0; byte_strobe = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL %s_we: got %b want 0", tag, bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 6'd0) begin n_fail++; $display("FAIL %s_addr: got %0d want 0", tag, bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h0) begin n_fail++; $display("FAIL %s_wdata: got %h want 0", tag, bus.mem_wdata); end
    n_checks++; if (byte_idx !== 2'd0) begin n_fail++; $display("FAIL %s_idx: got %0d want 0", tag, byte_idx); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done: got %b want 0", tag, done); end
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL %s_dropped: got %b want 0", tag, dropped); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL %s_error: got %b want 0", tag, error); end
  endtask

  task automatic test_reset;
    #25;
    check_reset_values("reset");
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic test_single_word;
    w0 = we_count;
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10);
    n_checks++; if (byte_idx !== 2'd3) begin n_fail++; $display("FAIL single_idx3: got %0d want 3", byte_idx); end
    send_byte(8'h20);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL single_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 6'd0) begin n_fail++; $display("FAIL single_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h20100013) begin n_fail++; $display("FAIL single_wdata: got %h want 20100013", bus.mem_wdata); end
    n_checks++; if (byte_idx !== 2'd0) begin n_fail++; $display("FAIL single_idx0: got %0d want 0", byte_idx); end
    idle(SETTLE);
    n_checks++; if (bus.mem_addr !== 6'd1) begin n_fail++; $display("FAIL single_next_addr: got %0d want 1", bus.mem_addr); end
    n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL single_we_pulses: got %0d want 1", we_count - w0); end
    n_checks++; if (ram[0] !== 32'h20100013) begin n_fail++; $display("FAIL single_ram0: got %h want 20100013", ram[0]); end
  endtask

  task automatic test_full_load;
    pulse_clear(1'b0, 8'h00);
    w0 = we_count;
    for (int w = 0; w < WORDS; w++) begin
      send_word({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
      if (w == WORDS - 2) begin
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_early: got %b want 0", done); end
      end
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b want 1", done); end
    n_checks++; if (bus.mem_addr !== 6'd63) begin n_fail++; $display("FAIL full_addr: got %0d want 63", bus.mem_addr); end
    n_checks++; if (we_count - w0 !== 64) begin n_fail++; $display("FAIL full_we_pulses: got %0d want 64", we_count - w0); end
    n_checks++; if (ram[0] !== 32'h03020100) begin n_fail++; $display("FAIL full_ram0: got %h want 03020100", ram[0]); end
    n_checks++; if (ram[63] !== 32'hFFFEFDFC) begin n_fail++; $display("FAIL full_ram63: got %h want fffefdfc", ram[63]); end
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL full_no_drop: got %b want 0", dropped); end
    send_byte(8'hAA);
    idle(4);
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL full_drop: got %b want 1", dropped); end
    n_checks++; if (we_count - w0 !== 64) begin n_fail++; $display("FAIL full_extra_we: got %0d want 64", we_count - w0); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done_hold: got %b want 1", done); end
  endtask

  task automatic test_clear_mid_word;
    pulse_clear(1'b1, 8'h5A);
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL clr_full_dropped: got %b want 0", dropped); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL clr_full_done: got %b want 0", done); end
    w0 = we_count;
    send_byte(8'h11); send_byte(8'h22);
    n_checks++; if (byte_idx !== 2'd2) begin n_fail++; $display("FAIL clr_idx2: got %0d want 2", byte_idx); end
    pulse_clear(1'b1, 8'h33);
    n_checks++; if (byte_idx !== 2'd0) begin n_fail++; $display("FAIL clr_idx: got %0d want 0", byte_idx); end
    n_checks++; if (bus.mem_addr !== 6'd0) begin n_fail++; $display("FAIL clr_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL clr_dropped: got %b want 0", dropped); end
    idle(4);
    n_checks++; if (we_count - w0 !== 0) begin n_fail++; $display("FAIL clr_no_write: got %0d want 0", we_count - w0); end
    send_word(32'hDEADBEEF);
    n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL clr_we_pulses: got %0d want 1", we_count - w0); end
    n_checks++; if (last_addr !== 6'd0) begin n_fail++; $display("FAIL clr_wr_addr: got %0d want 0", last_addr); end
    n_checks++; if (last_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clr_wr_data: got %h want deadbeef", last_data); end
    n_checks++; if (bus.mem_addr !== 6'd1) begin n_fail++; $display("FAIL clr_next_addr: got %0d want 1", bus.mem_addr); end
  endtask

  task automatic test_reset_mid_word;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    n_checks++; if (byte_idx !== 2'd3) begin n_fail++; $display("FAIL rst_idx3: got %0d want 3", byte_idx); end
    @(posedge clock); #5;
    reset = 1'b0;
    #1;
    check_reset_values("rst_mid");
    @(posedge clock); #1;
    reset = 1'b1;
    w0 = we_count;
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    idle(4);
    n_checks++; if (we_count - w0 !== 0) begin n_fail++; $display("FAIL rst_no_write: got %0d want 0", we_count - w0); end
    send_byte(8'h77);
    n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_we: got %b want 1", bus.mem_we); end
    n_checks++; if (bus.mem_addr !== 6'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", bus.mem_addr); end
    n_checks++; if (bus.mem_wdata !== 32'h77665544) begin n_fail++; $display("FAIL rst_wdata: got %h want 77665544", bus.mem_wdata); end
    idle(SETTLE);
  endtask

  task automatic test_back_to_back;
    pulse_clear(1'b0, 8'h00);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    w0 = we_count;
    for (int c = 0; c <= SP; c++) begin
      @(posedge clock); #1;
      byte_strobe = (c == 0 || c == SP);
      byte_in     = (c == 0) ? 8'hD4 : 8'hEE;
    end
    @(posedge clock); #1;
    byte_strobe = 1'b0;
    idle(6);
    n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL b2b_dropped: got %b want 1", dropped); end
    n_checks++; if (byte_idx !== 2'd0) begin n_fail++; $display("FAIL b2b_idx: got %0d want 0", byte_idx); end
    n_checks++; if (we_count - w0 !== 1) begin n_fail++; $display("FAIL b2b_we_pulses: got %0d want 1", we_count - w0); end
    n_checks++; if (last_data !== 32'hD4A3A2A1) begin n_fail++; $display("FAIL b2b_wr_data: got %h want d4a3a2a1", last_data); end
    n_checks++; if (bus.mem_wdata !== 32'hD4A3A2A1) begin n_fail++; $display("FAIL b2b_wdata_stable: got %h want d4a3a2a1", bus.mem_wdata); end
    n_checks++; if (bus.mem_addr !== 6'd1) begin n_fail++; $display("FAIL b2b_addr: got %0d want 1", bus.mem_addr); end
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL b2b_error: got %b want 0", error); end
  endtask

`ifdef INST_LOADER_VERIFY_EN
  task automatic test_verify_error;
    pulse_clear(1'b0, 8'h00);
    w0 = we_count;
    corrupt_en = 1'b1;
    send_word(32'h11111111);
    send_word(32'h22222222);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL ver_error_early: got %b want 0", error); end
    send_word(32'h33333333);
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ver_error: got %b want 1", error); end
    send_word(32'h44444444);
    n_checks++; if (last_addr !== 6'd3) begin n_fail++; $display("FAIL ver_word3_addr: got %0d want 3", last_addr); end
    n_checks++; if (we_count - w0 !== 4) begin n_fail++; $display("FAIL ver_we_pulses: got %0d want 4", we_count - w0); end
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL ver_error_sticky: got %b want 1", error); end
    n_checks++; if (ram[2] !== 32'h33333313) begin n_fail++; $display("FAIL ver_ram2: got %h want 33333313", ram[2]); end
    corrupt_en = 1'b0;
    pulse_clear(1'b0, 8'h00);
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL ver_error_clear: got %b want 0", error); end
  endtask
`endif

  initial begin
    for (int i = 0; i < WORDS; i++) ram[i] = 32'h0;
    test_reset;
    test_single_word;
    test_full_load;
    test_clear_mid_word;
    test_reset_mid_word;
    test_back_to_back;
`ifdef INST_LOADER_VERIFY_EN
    test_verify_error;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Writer-side companion to the instruction fetch path. It assembles 32-bit instruction words from bytes entered on the board switches, one byte per debounced button pulse, and writes them sequentially into the 64-word instruction RAM through its write port. The fetch/display path later reads the same words back. The block sits between the key debouncer's single-cycle pulse output and the instruction RAM's port A.

## Interface
Parameters:
- ADDR_W, 6, word-address width of the instruction RAM
- WORDS, 64, number of words to load before FULL; must be ≤ 2^ADDR_W

Ports:
- clock  in  1  system clock, 50 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-low; clock clock
- clear  in  1  synchronous restart: address 0, byte index 0, flags cleared
- byte_in  in  8  byte from switches, sampled on the byte_strobe cycle
- byte_strobe  in  1  single-cycle pulse from the debouncer, one per byte
- mem_rdata  in  32  RAM read data, one-cycle read latency
- mem_we  out  1  RAM write enable, exactly one cycle per word
- mem_addr  out  ADDR_W  RAM word address
- mem_wdata  out  32  assembled word
- byte_idx  out  2  next byte position to be filled (0..3)
- done  out  1  high in FULL
- dropped  out  1  sticky: a strobe arrived outside COLLECT
- error  out  1  sticky: readback mismatch (verify builds only)

## Operation
- Byte order is little-endian: byte 0 goes to wdata[7:0], byte 3 to wdata[31:24], matching the display Select order.
- FSM states: COLLECT, WRITE, VERIFY_WAIT, VERIFY_CMP, FULL.
- COLLECT: on byte_strobe, latch byte_in into lane byte_idx and increment byte_idx. If byte_idx was 3, byte_idx wraps to 0 and the FSM moves to WRITE.
- WRITE: mem_we=1 for one cycle with mem_addr=current address and mem_wdata=the assembled word. Next state is VERIFY_WAIT in verify builds; otherwise the address advances.
- VERIFY_WAIT: mem_we=0, mem_addr held.
- VERIFY_CMP: if mem_rdata≠mem_wdata, set error. Then advance the address.
- Address advance: if the address = WORDS-1, go to FULL with the address held at WORDS-1. Otherwise increment the address and return to COLLECT.
- FULL: done=1. Stays in FULL until clear or reset.
- Strobes in WRITE, VERIFY_WAIT, VERIFY_CMP or FULL are discarded and set dropped.
- clear in any state: next cycle the FSM is in COLLECT, address=0, byte_idx=0, dropped=0, error=0, mem_we=0. A clear coincident with byte_strobe discards the byte and does not set dropped. A clear during WRITE still allows that cycle's write to complete (mem_we already asserted).
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, byte_idx=0, done=0, dropped=0, error=0, state COLLECT.
- Reset mid-word: partial bytes are lost and nothing is written.

## Timing
- Strobe with byte_idx=3 at cycle N: mem_we=1 at N+1.
- Verify build: VERIFY_WAIT at N+2, VERIFY_CMP at N+3, COLLECT with new address at N+4.
- Non-verify build: COLLECT with new address at N+2.
- mem_wdata is registered and stable from N+1 until the next byte is latched.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Minimum strobe spacing accepted without drop: 4 cycles in verify builds, 2 cycles otherwise. Debounced pulses are ≥20 ms apart, so drops only occur with bench stimulus.

## Configuration
- INST_LOADER_VERIFY_EN defined: the VERIFY_WAIT and VERIFY_CMP states exist and error is live.
- INST_LOADER_VERIFY_EN undefined: WRITE goes directly to address advance, error is tied to 0, and mem_rdata is unused.

## Test plan
- Strobe bytes 0x13,0x00,0x10,0x20 → one mem_we pulse, addr 0, wdata 0x20100013, byte_idx returns to 0, address becomes 1.
- Load 64 words (256 strobes) → done=1 after the write to addr 63; a 257th strobe sets dropped and causes no mem_we.
- Verify build with RAM model corrupting bit 5 at addr 2 → error=1 after the word-2 compare; words 3+ still written.
- Two strobes 2 cycles apart straddling a word boundary (verify build) → second byte dropped, dropped=1, byte_idx=0.
- Two bytes entered, then clear coincident with a strobe → byte_idx=0, addr=0, no write, dropped=0; the next 4 bytes are written to addr 0.
- Reset asserted mid-word after 3 bytes → all outputs at reset values immediately, no mem_we until 4 fresh strobes.
